mode_sequencer: RTL and testbench
=================================

Name: mode_sequencer

Overview:
- Top-level user-interface controller for the multimode clock.
- Turns three debounced push-buttons into:
  - the 2-bit display mode;
  - an edit state machine;
  - single-cycle increment strobes for the time-field counters.
- Sits between the button debouncers and the clock, alarm, stopwatch and timer datapaths.
- Owns mode sequencing and arbitrates which datapath receives edit/increment events.

Parameters:
- NUM_MODES, 4: number of modes; mode wraps from NUM_MODES-1 to 0.
- TIMEOUT_S, 10: seconds without any press before edit state auto-exits to RUN; range 1..255.
- MODE_W, 2: width of mode output; must satisfy 2**MODE_W >= NUM_MODES.

Ports:
- clk  in  1  system clock; all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- mode_btn  in  1  debounced mode button, asynchronous to clk, active-high.
- set_btn  in  1  debounced set button, active-high.
- inc_btn  in  1  debounced increment button, active-high.
- tick_1hz  in  1  one-clk-wide pulse once per second, synchronous to clk.
- mode  out  MODE_W  current mode: 0 CLOCK, 1 ALARM, 2 STOPWATCH, 3 TIMER.
- editing  out  1  high in EDIT_HR or EDIT_MIN.
- field_sel  out  1  0 = hours field, 1 = minutes field; valid while editing.
- inc_hr  out  1  one-cycle strobe: increment hours of the datapath selected by mode.
- inc_min  out  1  one-cycle strobe: increment minutes of the datapath selected by mode.
- sw_run  out  1  stopwatch run/stop level.
- sw_clear  out  1  one-cycle stopwatch clear strobe.
- blink  out  1  display blanking for the field being edited.

Behaviour:
- Reset (async, resetn low): mode=0, FSM=RUN, editing=0, field_sel=0, inc_hr=0, inc_min=0, sw_run=0, sw_clear=0, blink=0, timeout counter=0, synchronizers cleared.
- Reset released mid-edit returns to RUN with mode=0; no strobe is emitted on release.
- Each button:
  - 2-flop synchronizer, then rising-edge detect giving a 1-cycle press.
  - Press is valid 3 clk after the button rises; outputs update 1 clk later (total latency 4 clk, fixed).
  - A held button gives exactly one press.
- Simultaneous presses in the same cycle: priority set > mode > inc; lower-priority presses are dropped.
- FSM states: RUN, EDIT_HR, EDIT_MIN.
- RUN:
  - mode press: mode <= (mode==NUM_MODES-1) ? 0 : mode+1.
  - set press, mode != STOPWATCH: go to EDIT_HR, field_sel=0.
  - set press, mode == STOPWATCH: toggle sw_run; FSM stays RUN.
  - inc press, mode == STOPWATCH and sw_run==0: sw_clear pulses 1 clk.
  - inc press with sw_run==1, or in any other mode: ignored.
- EDIT_HR:
  - set press: go to EDIT_MIN, field_sel=1.
  - inc press: inc_hr pulses 1 clk.
  - mode press: ignored; mode is frozen while editing.
- EDIT_MIN:
  - set press: go to RUN, field_sel=0.
  - inc press: inc_min pulses 1 clk.
- Timeout:
  - 8-bit counter, cleared on any press and on EDIT entry.
  - Increments on tick_1hz while editing.
  - Reaching TIMEOUT_S forces RUN on that cycle.
  - A press in the same cycle as the timeout wins: counter clears, no exit.
- editing = (state != RUN), registered.
- inc_hr, inc_min and sw_clear are never high together and never high for 2 consecutive cycles.
- sw_run persists across mode changes; only reset or a set press in STOPWATCH changes it.

Optional Feature:
- Macro: MODE_SEQUENCER_BLINK_EN.
- Defined:
  - blink toggles on each tick_1hz while editing.
  - blink is forced 0 on entry to RUN and on every inc press, so the edited value is visible right after an increment.
- Undefined: blink is tied to 0 and the toggle flop is not built.

Decomposition:
- Package mode_seq_pkg:
  - mode encodings MODE_CLOCK=0, MODE_ALARM=1, MODE_STOPWATCH=2, MODE_TIMER=3;
  - FSM state encodings ST_RUN, ST_EDIT_HR, ST_EDIT_MIN;
  - TIMEOUT counter width 8.
- Sub-module btn_press (2-flop synchronizer + rising-edge detect, ports clk, resetn, btn, press), instantiated three times.

Test Plan:
- Mode wrap: reset, then 5 mode presses spaced 10 clk -> mode 1,2,3,0,1; each change exactly 4 clk after the button rises.
- Edit sequence: mode=0, then set, inc, inc, set, inc, set -> inc_hr pulses twice, inc_min once; editing high from the first set to the third set; field_sel 0 then 1 then 0.
- Stopwatch: mode=2; set -> sw_run=1; inc -> no sw_clear; set -> sw_run=0; inc -> sw_clear single 1-clk pulse; editing stays 0 throughout.
- Timeout: TIMEOUT_S=3; enter EDIT_HR, apply 3 tick_1hz -> RUN on the third tick. Repeat with an inc press coinciding with the third tick -> remains EDIT_HR, counter restarts.
- Priority and hold: set and mode rise in the same cycle in RUN, mode=1 -> EDIT_HR, mode stays 1. Hold inc high for 100 clk -> exactly one inc_hr.
- Async reset mid-edit: in EDIT_MIN with sw_run=1, pulse resetn low between clk edges -> all outputs 0 immediately. With MODE_SEQUENCER_BLINK_EN, also check blink toggles per tick while editing.

Source files
------------

// File: rtl/mode_seq_pkg.sv
// rtl/mode_seq_pkg.sv - shared encodings for the multimode clock mode sequencer
package mode_seq_pkg;

    localparam int MODE_CLOCK     = 0;
    localparam int MODE_ALARM     = 1;
    localparam int MODE_STOPWATCH = 2;
    localparam int MODE_TIMER     = 3;

    // width of the edit inactivity counter (seconds)
    localparam int TMO_W = 8;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_EDIT_HR  = 2'd1,
        ST_EDIT_MIN = 2'd2
    } seq_state_t;

endpackage

// File: rtl/btn_press.sv
// rtl/btn_press.sv - 2-flop synchronizer plus registered rising-edge detect for one button
module btn_press (
    input  logic clk,
    input  logic resetn,
    input  logic btn,
    output logic press
);

    logic sync1;
    logic sync2;
    logic prev;

    // synchronize the raw level, keep the previous synced level, register a one-cycle press
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
            press <= sync2 & ~prev;
        end
    end

endmodule

// File: rtl/mode_sequencer.sv
// rtl/mode_sequencer.sv - button-driven mode/edit sequencer; optional field blink via MODE_SEQUENCER_BLINK_EN
module mode_sequencer #(
    parameter int NUM_MODES = 4,
    parameter int TIMEOUT_S = 10,
    parameter int MODE_W    = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mode_btn,
    input  logic              set_btn,
    input  logic              inc_btn,
    input  logic              tick_1hz,
    output logic [MODE_W-1:0] mode,
    output logic              editing,
    output logic              field_sel,
    output logic              inc_hr,
    output logic              inc_min,
    output logic              sw_run,
    output logic              sw_clear,
    output logic              blink
);

    import mode_seq_pkg::*;

    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);
    localparam logic [MODE_W-1:0] MODE_SW   = MODE_W'(MODE_STOPWATCH);
    // a tick arriving while the counter sits here is the one that expires the edit
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_S - 1);

    logic mode_p;
    logic set_p;
    logic inc_p;

    seq_state_t       state;
    logic [TMO_W-1:0] tcount;

    btn_press u_mode_press (.clk(clk), .resetn(resetn), .btn(mode_btn), .press(mode_p));
    btn_press u_set_press  (.clk(clk), .resetn(resetn), .btn(set_btn),  .press(set_p));
    btn_press u_inc_press  (.clk(clk), .resetn(resetn), .btn(inc_btn),  .press(inc_p));

`ifndef MODE_SEQUENCER_BLINK_EN
    assign blink = 1'b0;
`endif

    // edit state machine; set beats mode beats inc, any press beats the inactivity timeout
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_RUN;
            mode      <= '0;
            editing   <= 1'b0;
            field_sel <= 1'b0;
            inc_hr    <= 1'b0;
            inc_min   <= 1'b0;
            sw_run    <= 1'b0;
            sw_clear  <= 1'b0;
            tcount    <= '0;
`ifdef MODE_SEQUENCER_BLINK_EN
            blink     <= 1'b0;
`endif
        end else begin
            inc_hr   <= 1'b0;
            inc_min  <= 1'b0;
            sw_clear <= 1'b0;
            case (state)
                ST_RUN: begin
                    tcount <= '0;
                    if (set_p) begin
                        if (mode == MODE_SW) begin
                            sw_run <= ~sw_run;
                        end else begin
                            state     <= ST_EDIT_HR;
                            editing   <= 1'b1;
                            field_sel <= 1'b0;
                        end
                    end else if (mode_p) begin
                        mode <= (mode == MODE_LAST) ? '0 : mode + 1'b1;
                    end else if (inc_p && (mode == MODE_SW) && !sw_run) begin
                        sw_clear <= 1'b1;
                    end
                end
                ST_EDIT_HR, ST_EDIT_MIN: begin
`ifdef MODE_SEQUENCER_BLINK_EN
                    if (tick_1hz) begin
                        blink <= ~blink;
                    end
`endif
                    if (set_p || mode_p || inc_p) begin
                        tcount <= '0;
                    end else if (tick_1hz) begin
                        tcount <= tcount + 1'b1;
                    end
                    if (set_p) begin
                        if (state == ST_EDIT_HR) begin
                            state     <= ST_EDIT_MIN;
                            field_sel <= 1'b1;
                        end else begin
                            state     <= ST_RUN;
                            editing   <= 1'b0;
                            field_sel <= 1'b0;
`ifdef MODE_SEQUENCER_BLINK_EN
                            blink     <= 1'b0;
`endif
                        end
                    end else if (mode_p) begin
                        // mode is frozen while editing; the press only restarts the timeout
                    end else if (inc_p) begin
                        if (state == ST_EDIT_HR) begin
                            inc_hr <= 1'b1;
                        end else begin
                            inc_min <= 1'b1;
                        end
`ifdef MODE_SEQUENCER_BLINK_EN
                        blink <= 1'b0;
`endif
                    end else if (tick_1hz && (tcount == TMO_LAST)) begin
                        state     <= ST_RUN;
                        editing   <= 1'b0;
                        field_sel <= 1'b0;
`ifdef MODE_SEQUENCER_BLINK_EN
                        blink     <= 1'b0;
`endif
                    end
                end
                default: begin
                    state     <= ST_RUN;
                    editing   <= 1'b0;
                    field_sel <= 1'b0;
                    tcount    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mode_sequencer.sv
// tb/tb_mode_sequencer.sv - scoreboard bench for mode_sequencer with a cycle-level reference model
module tb_mode_sequencer;

    localparam int NUM_MODES = 4;
    localparam int TIMEOUT_S = 3;
    localparam int MODE_W    = 2;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic tick   = 1'b0;
    logic [2:0] btns = '0;   // [0] mode, [1] set, [2] inc

    logic [MODE_W-1:0] mode;
    logic editing, field_sel, inc_hr, inc_min, sw_run, sw_clear, blink;
    logic [9:0] dut_vec;
    assign dut_vec = {mode, editing, field_sel, inc_hr, inc_min, sw_run, sw_clear, blink};

    mode_sequencer #(.NUM_MODES(NUM_MODES), .TIMEOUT_S(TIMEOUT_S), .MODE_W(MODE_W)) dut (
        .clk(clk), .resetn(resetn),
        .mode_btn(btns[0]), .set_btn(btns[1]), .inc_btn(btns[2]), .tick_1hz(tick),
        .mode(mode), .editing(editing), .field_sel(field_sel),
        .inc_hr(inc_hr), .inc_min(inc_min), .sw_run(sw_run), .sw_clear(sw_clear), .blink(blink)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int sb_checks = 0;
    int n_hr = 0, n_min = 0, n_clr = 0, n_edit = 0;

    typedef struct { int at; int b; } ev_t;
    ev_t        evq[$];
    logic [9:0] sb[$];
    logic [9:0] sb_exp;

    // reference model state: field -1 = running, 0 = hours, 1 = minutes
    int   m_cyc, m_mode, m_field, m_idle;
    bit   m_sw_run, m_blink;
    bit [2:0] m_prev;

    // reference model: a press takes effect 3 edges after the edge that first samples the rise
    always @(posedge clk or negedge resetn) begin
        bit [2:0] p;
        bit hr, mn, clr;
        int sel;
        ev_t e;
        if (!resetn) begin
            m_cyc = 0; m_mode = 0; m_field = -1; m_idle = 0;
            m_sw_run = 0; m_blink = 0; m_prev = '0;
            evq.delete();
            sb.delete();
        end else begin
            m_cyc++;
            p = '0; hr = 0; mn = 0; clr = 0;
            while (evq.size() > 0 && evq[0].at == m_cyc) begin
                p[evq[0].b] = 1'b1;
                void'(evq.pop_front());
            end
            for (int b = 0; b < 3; b++) begin
                if (btns[b] && !m_prev[b]) begin
                    e.at = m_cyc + 3;
                    e.b  = b;
                    evq.push_back(e);
                end
            end
            m_prev = btns;
            sel = p[1] ? 1 : (p[0] ? 2 : (p[2] ? 3 : 0));
            if (m_field < 0) begin
                if (sel == 1) begin
                    if (m_mode == 2) m_sw_run = !m_sw_run;
                    else begin m_field = 0; m_idle = 0; end
                end else if (sel == 2) begin
                    m_mode = (m_mode + 1) % NUM_MODES;
                end else if (sel == 3 && m_mode == 2 && !m_sw_run) begin
                    clr = 1;
                end
            end else begin
`ifdef MODE_SEQUENCER_BLINK_EN
                if (tick) m_blink = !m_blink;
`endif
                if (sel != 0) m_idle = 0;
                else if (tick) m_idle++;
                if (sel == 1) m_field = (m_field == 0) ? 1 : -1;
                else if (sel == 3) begin
                    if (m_field == 0) hr = 1; else mn = 1;
                    m_blink = 0;
                end
                if (m_field >= 0 && m_idle >= TIMEOUT_S) m_field = -1;
                if (m_field < 0) begin m_blink = 0; m_idle = 0; end
            end
            sb.push_back({2'(m_mode), (m_field >= 0), (m_field == 1), hr, mn, m_sw_run, clr, m_blink});
        end
    end

    // monitor: one expected snapshot per clock, compared away from the active edge
    always @(negedge clk) begin
        if (resetn) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow t=%0t no expected entry", $time);
            end else begin
                sb_exp = sb.pop_front();
                sb_checks++;
                if (dut_vec !== sb_exp) begin
                    errors++;
                    $display("FAIL outputs t=%0t got=%b exp=%b (mode,edit,fsel,hr,min,run,clr,blink)",
                             $time, dut_vec, sb_exp);
                end
            end
        end
    end

    // strobe and level counters for directed checks
    always @(negedge clk) begin
        if (resetn) begin
            n_hr   += int'(inc_hr);
            n_min  += int'(inc_min);
            n_clr  += int'(sw_clear);
            n_edit += int'(editing);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic tap(input int b);
        btns[b] = 1'b1;
        step(4);
        btns[b] = 1'b0;
        step(6);
    endtask

    task automatic one_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(4);
    endtask

    initial begin
        step(3);
        chk("reset_state", int'(dut_vec), 0);
        @(negedge clk);
        #1 resetn = 1'b1;
        step(1);

        // mode wrap with fixed 4-clock latency
        for (int i = 0; i < 5; i++) begin
            btns[0] = 1'b1;
            step(3);
            chk("mode_before_latency", int'(mode), i % 4);
            step(1);
            chk("mode_at_latency", int'(mode), (i + 1) % 4);
            btns[0] = 1'b0;
            step(6);
        end

        // edit sequence from CLOCK mode
        tap(0); tap(0); tap(0);
        chk("mode_back_to_clock", int'(mode), 0);
        n_hr = 0; n_min = 0;
        tap(1);
        chk("edit_enter", int'(editing), 1);
        chk("edit_field_hr", int'(field_sel), 0);
        tap(2); tap(2);
        tap(1);
        chk("edit_field_min", int'(field_sel), 1);
        tap(2);
        tap(1);
        chk("edit_exit", int'(editing), 0);
        chk("edit_field_back", int'(field_sel), 0);
        chk("inc_hr_count", n_hr, 2);
        chk("inc_min_count", n_min, 1);

        // stopwatch run/clear
        tap(0); tap(0);
        chk("mode_stopwatch", int'(mode), 2);
        n_clr = 0; n_edit = 0;
        tap(1);
        chk("sw_run_on", int'(sw_run), 1);
        tap(2);
        chk("sw_clear_ignored", n_clr, 0);
        tap(1);
        chk("sw_run_off", int'(sw_run), 0);
        tap(2);
        chk("sw_clear_once", n_clr, 1);
        chk("sw_no_editing", n_edit, 0);

        // timeout after TIMEOUT_S ticks, and a press on the expiring tick wins
        tap(0);
        tap(1);
        chk("tmo_enter", int'(editing), 1);
        one_tick(); one_tick();
        chk("tmo_before", int'(editing), 1);
        tick = 1'b1; step(1);
        chk("tmo_exit", int'(editing), 0);
        tick = 1'b0; step(4);
        tap(1);
        one_tick(); one_tick();
        btns[2] = 1'b1;
        step(3);
        tick = 1'b1; step(1);
        chk("tmo_press_wins", int'(editing), 1);
        chk("tmo_press_inc", int'(inc_hr), 1);
        tick = 1'b0; btns[2] = 1'b0;
        step(5);
        one_tick(); one_tick();
        chk("tmo_restarted", int'(editing), 1);
        tick = 1'b1; step(1);
        chk("tmo_exit_again", int'(editing), 0);
        tick = 1'b0; step(4);

        // set beats mode in the same cycle; a held inc gives one strobe
        tap(0); tap(0);
        chk("prio_mode_alarm", int'(mode), 1);
        btns[0] = 1'b1; btns[1] = 1'b1;
        step(4);
        chk("prio_editing", int'(editing), 1);
        chk("prio_mode_kept", int'(mode), 1);
        btns = '0;
        step(6);
        n_hr = 0;
        btns[2] = 1'b1;
        step(100);
        btns[2] = 1'b0;
        step(6);
        chk("hold_one_inc", n_hr, 1);
        tap(1); tap(1);
        chk("hold_exit", int'(editing), 0);

        // asynchronous reset in EDIT_MIN with the stopwatch running
        tap(0);
        tap(1);
        tap(0);
        tap(1);
        tap(1);
        chk("rst_pre_field", int'(field_sel), 1);
        chk("rst_pre_run", int'(sw_run), 1);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1 chk("async_reset", int'(dut_vec), 0);
        @(negedge clk);
        #1 resetn = 1'b1;
        step(6);
        chk("post_reset_mode", int'(mode), 0);

        // randomized button/tick traffic against the model
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (btns[b]) begin
                    if ($urandom_range(3) == 0) btns[b] = 1'b0;
                end else if ($urandom_range(39) == 0) begin
                    btns[b] = 1'b1;
                end
            end
            tick = ($urandom_range(7) == 0);
            step(1);
        end
        btns = '0;
        tick = 1'b0;
        step(10);
        chk("sb_activity", int'(sb_checks > 3000), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
